// File: rtl/lc3b_mem_arbiter.sv
// lc3b_mem_arbiter
// Purpose : shares the single physical memory port between instruction fetch
//           (IF/ID) and data access (MEM). Data wins by default; a starvation
//           counter forces a fetch grant after STARVE_LIMIT consecutive data
//           grants issued while a fetch was waiting.
// Latency : grant on the first edge a request is seen in IDLE; pmem strobes
//           high from the next cycle; x_resp is combinational with pmem_resp;
//           back in IDLE one edge after pmem_resp.
// Backpressure: requesters hold level requests until their x_resp pulse;
//           pmem_* are held stable from captured registers until pmem_resp.
// Ports   : clk, rst_n (async active-low)
//           i_read/i_addr -> i_rdata/i_resp            (fetch requester)
//           d_read/d_write/d_addr/d_wdata/d_wmask -> d_rdata/d_resp (data)
//           pmem_read/write/addr/wdata/wmask, pmem_rdata/pmem_resp (memory)
//           busy : high whenever a transaction is being served
module lc3b_mem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_read,
  input  logic [15:0] i_addr,
  output logic [15:0] i_rdata,
  output logic        i_resp,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  input  logic [1:0]  d_wmask,
  output logic [15:0] d_rdata,
  output logic        d_resp,
  output logic        pmem_read,
  output logic        pmem_write,
  output logic [15:0] pmem_addr,
  output logic [15:0] pmem_wdata,
  output logic [1:0]  pmem_wmask,
  input  logic [15:0] pmem_rdata,
  input  logic        pmem_resp,
  output logic        busy
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SERVE_I = 2'd1;
  localparam logic [1:0] ST_SERVE_D = 2'd2;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [1:0]  state_q,  state_d;
  logic [3:0]  starve_q, starve_d;
  logic [15:0] addr_q,   addr_d;
  logic [15:0] wdata_q,  wdata_d;
  logic [1:0]  wmask_q,  wmask_d;
  logic        rd_q,     rd_d;
  logic        wr_q,     wr_d;

  logic d_req;
  logic starved;

  assign d_req   = d_read | d_write;
  // Fetch has watched LIMIT data grants go by: it takes the next slot.
  assign starved = i_read && (starve_q == LIMIT);

  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wmask_d  = wmask_q;
    rd_d     = rd_q;
    wr_d     = wr_q;

    case (state_q)
      ST_IDLE: begin
        if (d_req && !starved) begin
          state_d = ST_SERVE_D;
          addr_d  = d_addr;
          wdata_d = d_wdata;
          wmask_d = d_wmask;
          // A simultaneous read+write is treated as a write only.
          wr_d    = d_write;
          rd_d    = ~d_write;
          if (!i_read)
            starve_d = 4'd0;
          else if (starve_q != LIMIT)
            starve_d = starve_q + 4'd1;
        end else if (i_read) begin
          state_d  = ST_SERVE_I;
          addr_d   = i_addr;
          wdata_d  = 16'h0000;
          wmask_d  = 2'b00;
          rd_d     = 1'b1;
          wr_d     = 1'b0;
          starve_d = 4'd0;
        end
      end

      ST_SERVE_I, ST_SERVE_D: begin
        // Clearing the capture registers on completion drops the strobes
        // and leaves the physical port quiet in IDLE.
        if (pmem_resp) begin
          state_d = ST_IDLE;
          addr_d  = 16'h0000;
          wdata_d = 16'h0000;
          wmask_d = 2'b00;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
        end
      end

      default: begin
        state_d = ST_IDLE;
        addr_d  = 16'h0000;
        wdata_d = 16'h0000;
        wmask_d = 2'b00;
        rd_d    = 1'b0;
        wr_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      starve_q <= 4'd0;
      addr_q   <= 16'h0000;
      wdata_q  <= 16'h0000;
      wmask_q  <= 2'b00;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wmask_q  <= wmask_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
    end
  end

  assign pmem_read  = rd_q;
  assign pmem_write = wr_q;
  assign pmem_addr  = addr_q;
  assign pmem_wdata = wdata_q;
  assign pmem_wmask = wmask_q;

  // Responses only exist inside a SERVE state; a pmem_resp seen in IDLE
  // (e.g. left over from before a reset) never reaches a requester.
  assign i_resp  = (state_q == ST_SERVE_I) && pmem_resp;
  assign d_resp  = (state_q == ST_SERVE_D) && pmem_resp;
  assign i_rdata = i_resp ? pmem_rdata : 16'h0000;
  assign d_rdata = d_resp ? pmem_rdata : 16'h0000;

  assign busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_lc3b_mem_arbiter.sv
module tb_lc3b_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_read = 1'b0;
  logic [15:0] i_addr = '0;
  logic [15:0] i_rdata;
  logic        i_resp;
  logic        d_read = 1'b0;
  logic        d_write = 1'b0;
  logic [15:0] d_addr = '0;
  logic [15:0] d_wdata = '0;
  logic [1:0]  d_wmask = '0;
  logic [15:0] d_rdata;
  logic        d_resp;
  logic        pmem_read;
  logic        pmem_write;
  logic [15:0] pmem_addr;
  logic [15:0] pmem_wdata;
  logic [1:0]  pmem_wmask;
  logic [15:0] pmem_rdata = '0;
  logic        pmem_resp = 1'b0;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  lc3b_mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_wmask(d_wmask), .d_rdata(d_rdata), .d_resp(d_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_addr(pmem_addr),
    .pmem_wdata(pmem_wdata), .pmem_wmask(pmem_wmask),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        ird;
    logic [15:0] iaddr;
    logic        drd;
    logic        dwr;
    logic [15:0] daddr;
    logic [15:0] dwdata;
    logic [1:0]  dwmask;
    logic [15:0] prdata;
    logic        presp;
  } in_t;

  typedef struct packed {
    logic        pr;
    logic        pw;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [1:0]  wmask;
    logic        ir;
    logic [15:0] irdata;
    logic        dr;
    logic [15:0] drdata;
    logic        bsy;
  } out_t;

  typedef struct packed {
    in_t  in;
    out_t exp;
  } vec_t;

  localparam int NVEC = 15;
  vec_t vecs [NVEC];

  function automatic in_t mi(logic ir, logic [15:0] ia, logic dr, logic dw,
                             logic [15:0] da, logic [15:0] dwd, logic [1:0] dwm,
                             logic [15:0] prd, logic prs);
    in_t v;
    v.ird = ir; v.iaddr = ia; v.drd = dr; v.dwr = dw; v.daddr = da;
    v.dwdata = dwd; v.dwmask = dwm; v.prdata = prd; v.presp = prs;
    return v;
  endfunction

  function automatic out_t mo(logic pr, logic pw, logic [15:0] a, logic [15:0] wd,
                              logic [1:0] wm, logic ir, logic [15:0] ird,
                              logic dr, logic [15:0] drd, logic b);
    out_t o;
    o.pr = pr; o.pw = pw; o.addr = a; o.wdata = wd; o.wmask = wm;
    o.ir = ir; o.irdata = ird; o.dr = dr; o.drdata = drd; o.bsy = b;
    return o;
  endfunction

  function automatic out_t sample();
    out_t o;
    o.pr = pmem_read; o.pw = pmem_write; o.addr = pmem_addr;
    o.wdata = pmem_wdata; o.wmask = pmem_wmask; o.ir = i_resp;
    o.irdata = i_rdata; o.dr = d_resp; o.drdata = d_rdata; o.bsy = busy;
    return o;
  endfunction

  task automatic apply(input in_t v);
    i_read = v.ird; i_addr = v.iaddr; d_read = v.drd; d_write = v.dwr;
    d_addr = v.daddr; d_wdata = v.dwdata; d_wmask = v.dwmask;
    pmem_rdata = v.prdata; pmem_resp = v.presp;
  endtask

  task automatic check_out(input string name, input out_t exp);
    out_t act;
    act = sample();
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got rd=%b wr=%b addr=%h wd=%h wm=%b ir=%b ird=%h dr=%b drd=%h busy=%b, want rd=%b wr=%b addr=%h wd=%h wm=%b ir=%b ird=%h dr=%b drd=%h busy=%b",
               name, act.pr, act.pw, act.addr, act.wdata, act.wmask, act.ir,
               act.irdata, act.dr, act.drdata, act.bsy, exp.pr, exp.pw,
               exp.addr, exp.wdata, exp.wmask, exp.ir, exp.irdata, exp.dr,
               exp.drdata, exp.bsy);
    end
  endtask

  task automatic check_val(input string name, input logic [15:0] act,
                           input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  initial begin
    out_t zero;
    logic exp_is_d [6];
    logic [15:0] exp_addr;

    zero = mo(0, 0, 16'h0, 16'h0, 2'b00, 0, 16'h0, 0, 16'h0, 0);

    // Single fetch with 3-cycle memory, then a data write whose address
    // changes after grant, then simultaneous I + D(read+write), then a
    // stray pmem_resp in IDLE.
    vecs[0].in  = mi(1, 16'h3000, 0, 0, 16'h0, 16'h0, 2'b00, 16'h0, 0);
    vecs[0].exp = zero;
    vecs[1].in  = mi(1, 16'h3000, 0, 0, 16'h0, 16'h0, 2'b00, 16'h0, 0);
    vecs[1].exp = mo(1, 0, 16'h3000, 16'h0, 2'b00, 0, 16'h0, 0, 16'h0, 1);
    vecs[2].in  = vecs[1].in;
    vecs[2].exp = vecs[1].exp;
    vecs[3].in  = mi(1, 16'h3000, 0, 0, 16'h0, 16'h0, 2'b00, 16'h1234, 1);
    vecs[3].exp = mo(1, 0, 16'h3000, 16'h0, 2'b00, 1, 16'h1234, 0, 16'h0, 1);
    vecs[4].in  = mi(0, 16'h0, 0, 0, 16'h0, 16'h0, 2'b00, 16'h0, 0);
    vecs[4].exp = zero;
    vecs[5].in  = mi(0, 16'h0, 0, 1, 16'h4002, 16'hBEEF, 2'b10, 16'h0, 0);
    vecs[5].exp = zero;
    vecs[6].in  = mi(0, 16'h0, 0, 1, 16'h0000, 16'hBEEF, 2'b10, 16'h0, 0);
    vecs[6].exp = mo(0, 1, 16'h4002, 16'hBEEF, 2'b10, 0, 16'h0, 0, 16'h0, 1);
    vecs[7].in  = mi(0, 16'h0, 0, 1, 16'h0000, 16'hBEEF, 2'b10, 16'h5555, 1);
    vecs[7].exp = mo(0, 1, 16'h4002, 16'hBEEF, 2'b10, 0, 16'h0, 1, 16'h5555, 1);
    vecs[8].in  = mi(0, 16'h0, 0, 0, 16'h0, 16'h0, 2'b00, 16'h0, 0);
    vecs[8].exp = zero;
    vecs[9].in  = mi(1, 16'h3002, 1, 1, 16'h4004, 16'h1111, 2'b11, 16'h0, 0);
    vecs[9].exp = zero;
    vecs[10].in  = mi(1, 16'h3002, 1, 1, 16'h4004, 16'h1111, 2'b11, 16'hABCD, 1);
    vecs[10].exp = mo(0, 1, 16'h4004, 16'h1111, 2'b11, 0, 16'h0, 1, 16'hABCD, 1);
    vecs[11].in  = mi(1, 16'h3002, 0, 0, 16'h0, 16'h0, 2'b00, 16'h0, 0);
    vecs[11].exp = zero;
    vecs[12].in  = mi(1, 16'h3002, 0, 0, 16'h0, 16'h0, 2'b00, 16'h9876, 1);
    vecs[12].exp = mo(1, 0, 16'h3002, 16'h0, 2'b00, 1, 16'h9876, 0, 16'h0, 1);
    vecs[13].in  = mi(0, 16'h0, 0, 0, 16'h0, 16'h0, 2'b00, 16'hFFFF, 1);
    vecs[13].exp = zero;
    vecs[14].in  = mi(0, 16'h0, 0, 0, 16'h0, 16'h0, 2'b00, 16'h0, 0);
    vecs[14].exp = zero;

    exp_is_d = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

    #3;
    check_out("reset_state", zero);

    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      apply(vecs[i].in);
      #1;
      check_out($sformatf("vec%0d", i), vecs[i].exp);
      @(negedge clk);
    end

    // Starvation: fetch held high, data re-requested after each completion.
    for (int g = 0; g < 6; g++) begin
      i_read = 1'b1; i_addr = 16'h3100;
      d_read = 1'b1; d_write = 1'b0; d_addr = 16'h5000 + 16'(g);
      pmem_resp = 1'b0; pmem_rdata = 16'h0;
      #1;
      check_val($sformatf("starve_idle%0d", g), {15'd0, busy}, 16'd0);
      @(negedge clk);
      exp_addr = exp_is_d[g] ? (16'h5000 + 16'(g)) : 16'h3100;
      check_val($sformatf("starve_addr%0d", g), pmem_addr, exp_addr);
      pmem_resp = 1'b1; pmem_rdata = 16'h00A0 + 16'(g);
      #1;
      check_val($sformatf("starve_resp%0d", g), {14'd0, i_resp, d_resp},
                exp_is_d[g] ? 16'd1 : 16'd2);
      @(negedge clk);
      pmem_resp = 1'b0;
    end
    i_read = 1'b0; d_read = 1'b0;
    @(negedge clk);

    // Reset in the middle of a data write.
    d_write = 1'b1; d_addr = 16'h4444; d_wdata = 16'h7777; d_wmask = 2'b01;
    @(negedge clk);
    #1;
    check_val("rst_pre_write", {15'd0, pmem_write}, 16'd1);
    #1;
    rst_n = 1'b0;
    d_write = 1'b0;
    #1;
    check_out("rst_mid_txn", zero);
    @(negedge clk);
    rst_n = 1'b1;
    pmem_resp = 1'b1; pmem_rdata = 16'hDEAD;
    #1;
    check_out("rst_stale_resp", zero);
    @(negedge clk);
    pmem_resp = 1'b0;
    #1;
    check_out("rst_after_idle", zero);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
